// File: rtl/pipe_skid_reg.sv
// Pipeline-boundary register with a 2-entry skid buffer (valid/ready, registered in_ready).
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_reg_addr,
    input  logic               in_reg_we,
    input  logic [DATA_W-1:0]  in_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [RADDR_W-1:0] out_reg_addr,
    output logic               out_reg_we,
    output logic [DATA_W-1:0]  out_result,
    output logic [1:0]         occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    localparam int PAY_W = PC_W + RADDR_W + 1 + DATA_W;

    if (DATA_W < 1 || PC_W < 1 || RADDR_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_reg: all widths must be at least 1");
    end

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] m_pay_q, m_pay_d;
    logic [PAY_W-1:0] s_pay_q, s_pay_d;
    logic             m_v_q, m_v_d;
    logic             s_v_q, s_v_d;
    logic             m_we;
    logic             acc;
    logic             pop;

    assign in_pay = {in_pc, in_reg_addr, in_reg_we, in_result};
    assign {out_pc, out_reg_addr, m_we, out_result} = m_pay_q;

    assign in_ready   = ~s_v_q;
    assign out_valid  = m_v_q;
    assign out_reg_we = m_we & m_v_q;
    assign occupancy  = {1'b0, m_v_q} + {1'b0, s_v_q};

    assign acc = in_valid & ~s_v_q;
    assign pop = m_v_q & out_ready;

    always_comb begin
        m_v_d   = m_v_q;
        s_v_d   = s_v_q;
        m_pay_d = m_pay_q;
        s_pay_d = s_pay_q;
        if (flush) begin
            // Payload is left stale; only the valid flags matter after a flush.
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q) begin
            if (acc) begin
                m_pay_d = in_pay;
                m_v_d   = 1'b1;
            end
        end else if (pop) begin
            if (s_v_q) begin
                m_pay_d = s_pay_q;
                s_v_d   = 1'b0;
            end else if (acc) begin
                m_pay_d = in_pay;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (acc) begin
            s_pay_d = in_pay;
            s_v_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            m_pay_q <= '0;
            s_pay_q <= '0;
        end else begin
            m_v_q   <= m_v_d;
            s_v_q   <= s_v_d;
            m_pay_q <= m_pay_d;
            s_pay_q <= s_pay_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters are deliberately immune to flush; only reset clears them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_v_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!m_v_q) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
